// File: rtl/ifq_ctrl_if.sv
// Fetch-queue bus: instruction-memory handshake, redirect, and pre-decode outputs.
interface ifq_ctrl_if;
    logic        ic_req;
    logic [63:0] ic_addr;
    logic        ic_ack;
    logic [31:0] ic_data;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        stall_in;
    logic [63:0] pd_pc;
    logic [31:0] pd_ir;
    logic        pd_stall;

    // Environment side: memory model, redirect source, downstream stage.
    modport master (
        input  ic_req, ic_addr, pd_pc, pd_ir, pd_stall,
        output ic_ack, ic_data, flush, redirect_pc, stall_in
    );

    // Fetch-queue controller side.
    modport slave (
        output ic_req, ic_addr, pd_pc, pd_ir, pd_stall,
        input  ic_ack, ic_data, flush, redirect_pc, stall_in
    );
endinterface

// File: rtl/ifq_ctrl.sv
// Instruction fetch queue controller: one outstanding fetch, DEPTH-entry
// {pc, ir} FIFO feeding pre-decode. All state updates on the falling edge.
module ifq_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    ifq_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    state_t        state, state_nxt;
    logic [63:0]   fpc, fpc_nxt;
    logic [63:0]   mem_pc [DEPTH];
    logic [31:0]   mem_ir [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          empty, full, push, pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    // A flush wins over both queue operations in its cycle.
    assign push  = (state == WAIT) && bus.ic_ack && !bus.flush;
    assign pop   = !empty && !bus.stall_in && !bus.flush;

    assign bus.ic_req   = (state == WAIT);
    assign bus.ic_addr  = fpc;
    assign bus.pd_pc    = (!empty && !bus.flush) ? mem_pc[rd_ptr] : 64'd0;
    assign bus.pd_ir    = (!empty && !bus.flush) ? mem_ir[rd_ptr] : NOP;
    assign bus.pd_stall = bus.stall_in;

    // Next fetch state and fetch PC. In KILL an ack retires the dead request
    // even if a flush arrives together with it, otherwise we would wait forever.
    always_comb begin
        state_nxt = state;
        fpc_nxt   = fpc;
        case (state)
            IDLE:    if (!bus.flush && !full) state_nxt = WAIT;
            WAIT:    if (bus.ic_ack)          state_nxt = IDLE;
                     else if (bus.flush)      state_nxt = KILL;
            KILL:    if (bus.ic_ack)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush)  fpc_nxt = bus.redirect_pc;
        else if (push)  fpc_nxt = fpc + 64'd4;
    end

    // Control state, pointers and occupancy.
    always_ff @(negedge clk) begin
        if (rst) begin
            state  <= IDLE;
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(negedge clk) begin
        if (!rst && push) begin
            mem_pc[wr_ptr] <= fpc;
            mem_ir[wr_ptr] <= bus.ic_data;
        end
    end
endmodule

// File: tb/tb_ifq_ctrl.sv
// Self-checking bench for ifq_ctrl: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_ifq_ctrl;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed { logic [63:0] pc; logic [31:0] ir; } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntests = 0;
    int   nfail  = 0;

    ifq_ctrl_if bus();

    ifq_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: "a request is outstanding" and "its data is dead",
    // a fetch PC, and a plain queue of fetched entries.
    bit          m_out, m_kill;
    logic [63:0] m_fpc;
    ent_t        m_q[$];
    logic        e_req, e_stall;
    logic [63:0] e_addr, e_pc;
    logic [31:0] e_ir;

    // Drive one cycle of inputs after the rising edge, then form expectations.
    task automatic apply(input logic r, input logic f, input logic a, input logic [31:0] d,
                         input logic [63:0] rp, input logic s);
        @(posedge clk);
        #1;
        rst = r; bus.flush = f; bus.ic_ack = a; bus.ic_data = d;
        bus.redirect_pc = rp; bus.stall_in = s;
        #1;
        e_req   = m_out && !m_kill;
        e_addr  = m_fpc;
        e_stall = s;
        if (m_q.size() > 0 && !f) begin e_pc = m_q[0].pc; e_ir = m_q[0].ir; end
        else begin e_pc = 64'd0; e_ir = NOP; end
    endtask

    // Advance the model by one falling edge using the inputs now applied.
    task automatic step_model();
        int n;
        bit pushing, popping;
        if (rst) begin
            m_out = 0; m_kill = 0; m_fpc = RESET_PC; m_q.delete();
        end else begin
            n       = m_q.size();
            pushing = m_out && !m_kill && bus.ic_ack && !bus.flush;
            popping = (n > 0) && !bus.stall_in && !bus.flush;
            if (bus.flush) m_q.delete();
            else begin
                if (popping) void'(m_q.pop_front());
                if (pushing) m_q.push_back('{m_fpc, bus.ic_data});
            end
            if (!m_out) begin m_out = !bus.flush && (n < DEPTH); m_kill = 0; end
            else if (bus.ic_ack) begin m_out = 0; m_kill = 0; end
            else if (bus.flush) m_kill = 1;
            if (bus.flush) m_fpc = bus.redirect_pc;
            else if (pushing) m_fpc = m_fpc + 64'd4;
        end
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0);
        step_model();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 1, 1, $urandom, {$urandom, $urandom}, i[0]);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, bus.pd_stall} !== {1'b0, RESET_PC, 64'd0, NOP, i[0]}) begin
                nfail++;
                $display("FAIL reset: req=%b addr=%h pc=%h ir=%h st=%b, want req=0 addr=%h pc=0 ir=%h st=%b",
                         bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, bus.pd_stall, RESET_PC, NOP, i[0]);
            end
            step_model();
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            apply(0, 0, 1, 32'h0000_0093, 0, 0);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, bus.pd_stall} !== {e_req, e_addr, e_pc, e_ir, e_stall}) begin
                nfail++;
                $display("FAIL basic c%0d: req=%b addr=%h pc=%h ir=%h, want req=%b addr=%h pc=%h ir=%h",
                         c, bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, e_req, e_addr, e_pc, e_ir);
            end
            if (c == 1 || c == 3) begin
                ntests++;
                if (bus.ic_req !== 1'b1 || bus.ic_addr !== RESET_PC + 64'(4 * (c / 2))) begin
                    nfail++;
                    $display("FAIL basic_addr c%0d: req=%b addr=%h, want req=1 addr=%h",
                             c, bus.ic_req, bus.ic_addr, RESET_PC + 64'(4 * (c / 2)));
                end
            end
            if (c == 2) begin
                ntests++;
                if (bus.pd_ir !== 32'h0000_0093 || bus.pd_pc !== RESET_PC) begin
                    nfail++;
                    $display("FAIL basic_latency: pc=%h ir=%h, want pc=%h ir=00000093", bus.pd_pc, bus.pd_ir, RESET_PC);
                end
            end
            step_model();
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            apply(0, 0, 1, $urandom, 0, 1);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, bus.pd_stall} !== {e_req, e_addr, e_pc, e_ir, e_stall}) begin
                nfail++;
                $display("FAIL stall_fill c%0d: req=%b addr=%h pc=%h ir=%h, want req=%b addr=%h pc=%h ir=%h",
                         c, bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, e_req, e_addr, e_pc, e_ir);
            end
            step_model();
        end
        apply(0, 0, 1, 0, 0, 1);
        ntests++;
        if (bus.ic_req !== 1'b0 || bus.ic_addr !== RESET_PC + 64'd16 || bus.pd_stall !== 1'b1) begin
            nfail++;
            $display("FAIL stall_full: req=%b addr=%h st=%b, want req=0 addr=%h st=1",
                     bus.ic_req, bus.ic_addr, bus.pd_stall, RESET_PC + 64'd16);
        end
        step_model();
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 0, 0, 0, 0);
            ntests++;
            if ({bus.pd_pc, bus.pd_ir} !== {e_pc, e_ir} ||
                bus.pd_pc !== ((k < 4) ? RESET_PC + 64'(4 * k) : 64'd0)) begin
                nfail++;
                $display("FAIL stall_drain k%0d: pc=%h ir=%h, want pc=%h ir=%h", k, bus.pd_pc, bus.pd_ir, e_pc, e_ir);
            end
            step_model();
        end
    endtask

    task automatic test_flush_kill();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply(0, c == 1, c == 4, 32'hDEAD_BEEF, 64'h1000, 0);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir} !== {e_req, e_addr, e_pc, e_ir} ||
                bus.pd_ir === 32'hDEAD_BEEF) begin
                nfail++;
                $display("FAIL flush_kill c%0d: req=%b addr=%h pc=%h ir=%h, want req=%b addr=%h pc=%h ir=%h",
                         c, bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, e_req, e_addr, e_pc, e_ir);
            end
            if (c == 6) begin
                ntests++;
                if (bus.ic_req !== 1'b1 || bus.ic_addr !== 64'h1000) begin
                    nfail++;
                    $display("FAIL flush_kill_redirect: req=%b addr=%h, want req=1 addr=1000", bus.ic_req, bus.ic_addr);
                end
            end
            step_model();
        end
    endtask

    task automatic test_flush_ack();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(0, c == 5, (c == 1 || c == 3 || c == 5), 32'h100 + c, 64'h2000, 1);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir} !== {e_req, e_addr, e_pc, e_ir}) begin
                nfail++;
                $display("FAIL flush_ack c%0d: req=%b addr=%h pc=%h ir=%h, want req=%b addr=%h pc=%h ir=%h",
                         c, bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, e_req, e_addr, e_pc, e_ir);
            end
            if (c == 5 || c == 6) begin
                ntests++;
                if (bus.pd_ir !== NOP || bus.pd_pc !== 64'd0) begin
                    nfail++;
                    $display("FAIL flush_ack_nop c%0d: pc=%h ir=%h, want pc=0 ir=%h", c, bus.pd_pc, bus.pd_ir, NOP);
                end
            end
            if (c == 7) begin
                ntests++;
                if (bus.ic_req !== 1'b1 || bus.ic_addr !== 64'h2000) begin
                    nfail++;
                    $display("FAIL flush_ack_redirect: req=%b addr=%h, want req=1 addr=2000", bus.ic_req, bus.ic_addr);
                end
            end
            step_model();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply(0, 0, c[0], $urandom, 0, 1);
            step_model();
        end
        for (int k = 0; k < 7; k++) begin
            apply(0, 0, 0, 0, 0, 1);
            step_model();
            apply(0, 0, 1, $urandom, 0, 0);
            ntests++;
            if ({bus.ic_req, bus.pd_pc, bus.pd_ir} !== {e_req, e_pc, e_ir} || bus.pd_pc !== RESET_PC + 64'(4 * k)) begin
                nfail++;
                $display("FAIL wrap k%0d: req=%b pc=%h ir=%h, want req=1 pc=%h ir=%h",
                         k, bus.ic_req, bus.pd_pc, bus.pd_ir, RESET_PC + 64'(4 * k), e_ir);
            end
            step_model();
        end
        apply(0, 0, 0, 0, 0, 1);
        ntests++;
        if (bus.pd_pc !== RESET_PC + 64'd28 || bus.pd_ir !== e_ir || m_q.size() != 2) begin
            nfail++;
            $display("FAIL wrap_count: pc=%h ir=%h, want pc=%h ir=%h", bus.pd_pc, bus.pd_ir, RESET_PC + 64'd28, e_ir);
        end
        step_model();
    endtask

    task automatic test_rst_wait();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply(c == 2, 0, (c == 3 || c >= 5), (c == 3) ? 32'h0000_0BAD : 32'h55, 0, 0);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir} !== {e_req, e_addr, e_pc, e_ir} ||
                bus.pd_ir === 32'h0000_0BAD) begin
                nfail++;
                $display("FAIL rst_wait c%0d: req=%b addr=%h pc=%h ir=%h, want req=%b addr=%h pc=%h ir=%h",
                         c, bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, e_req, e_addr, e_pc, e_ir);
            end
            if (c == 3 || c == 4) begin
                ntests++;
                if (bus.ic_req !== (c == 4) || bus.ic_addr !== RESET_PC) begin
                    nfail++;
                    $display("FAIL rst_wait_req c%0d: req=%b addr=%h, want req=%b addr=%h",
                             c, bus.ic_req, bus.ic_addr, c == 4, RESET_PC);
                end
            end
            step_model();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            apply($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom_range(0, 1) == 1,
                  $urandom, {$urandom, $urandom}, $urandom_range(0, 99) < 35);
            ntests++;
            if ({bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, bus.pd_stall} !== {e_req, e_addr, e_pc, e_ir, e_stall}) begin
                nfail++;
                $display("FAIL random c%0d: req=%b addr=%h pc=%h ir=%h st=%b, want req=%b addr=%h pc=%h ir=%h st=%b",
                         c, bus.ic_req, bus.ic_addr, bus.pd_pc, bus.pd_ir, bus.pd_stall, e_req, e_addr, e_pc, e_ir, e_stall);
            end
            step_model();
        end
    endtask

    initial begin
        bus.flush = 0; bus.ic_ack = 0; bus.ic_data = 0; bus.redirect_pc = 0; bus.stall_in = 0;
        test_reset();
        test_basic();
        test_stall_full();
        test_flush_kill();
        test_flush_ack();
        test_wrap();
        test_rst_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/ifq_ctrl.md
IFQ_CTRL -- requirements
Module: ifq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports are named clk and rst, and every state update SHALL occur on the falling edge of clk.
REQ-002 Parameters SHALL be, one per line:
- DEPTH, default 4, queue entries (power of two, >=2).
- RESET_PC, default 64'h0000_0000_8000_0000, first fetch address.
- NOP, default 32'h0000_0013, bubble instruction.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ic_req  out  1  fetch request to instruction memory.
- ic_addr  out  64  fetch address.
- ic_ack  in  1  fetch data valid this cycle.
- ic_data  in  32  fetched instruction.
- flush  in  1  redirect the front end.
- redirect_pc  in  64  new fetch address, valid with flush.
- stall_in  in  1  downstream stage cannot accept.
- pd_pc  out  64  PC to pre-decode stage.
- pd_ir  out  32  instruction to pre-decode stage.
- pd_stall  out  1  stall to pre-decode stage.

Function
REQ-004 The block SHALL hold a fetch PC register (fpc), a DEPTH-entry FIFO of {pc[63:0], ir[31:0]}, and the following state:
- read and write pointers of log2(DEPTH) bits each, wrapping modulo DEPTH;
- a count of log2(DEPTH)+1 bits.
REQ-005 The fetch FSM SHALL have three states: IDLE, WAIT and KILL.
REQ-006 In IDLE, if count<DEPTH and flush=0, the FSM SHALL move to WAIT; otherwise it SHALL stay in IDLE.
REQ-007 ic_req SHALL be 1 exactly when the state is WAIT, and ic_addr SHALL always equal fpc.
REQ-008 In WAIT with ic_ack=1 and flush=0, the block SHALL:
- push {fpc, ic_data} into the FIFO;
- set fpc to fpc+4 (64-bit wrap-around);
- go to IDLE.
REQ-009 In WAIT with flush=1 and ic_ack=1, the block SHALL discard ic_data, load fpc from redirect_pc and go to IDLE.
REQ-010 In WAIT with flush=1 and ic_ack=0, the block SHALL load fpc from redirect_pc and go to KILL.
REQ-011 In KILL, ic_req SHALL be 0. On ic_ack=1 the block SHALL discard ic_data and go to IDLE. A flush in KILL SHALL reload fpc from redirect_pc and leave the state at KILL.
REQ-012 In IDLE, flush=1 SHALL load fpc from redirect_pc and leave the state at IDLE.
REQ-013 Pop condition: FIFO not empty, stall_in=0 and flush=0. A pop SHALL advance the read pointer.
REQ-014 When a push and a pop occur in the same cycle, both pointers SHALL advance and count SHALL be unchanged.
REQ-015 A push SHALL never occur while count==DEPTH. This is guaranteed by REQ-006, since count only decreases while in WAIT.
REQ-016 flush=1 SHALL, in that cycle, empty the FIFO (pointers and count to 0) and cancel any pop.
REQ-017 Outputs to the pre-decode stage (combinational, from the current state) SHALL be:
- pd_pc, pd_ir = head entry when the FIFO is non-empty and flush=0;
- otherwise pd_pc=0 and pd_ir=NOP.
REQ-018 pd_stall SHALL equal stall_in. An empty FIFO therefore injects NOP bubbles rather than stalling.
REQ-019 Minimum latency SHALL be 2 falling edges from IDLE with an empty FIFO to valid data on pd_ir, given an ic_ack on the first WAIT cycle:
- edge 1: IDLE to WAIT;
- edge 2: push.
REQ-020 Sustained throughput SHALL be one instruction per 2 cycles while ic_ack returns in the first WAIT cycle.

Reset
REQ-021 With rst=1 at a falling edge, the block SHALL set state=IDLE, fpc=RESET_PC, pointers=0 and count=0. rst SHALL take priority over flush, ic_ack and stall_in.
REQ-022 During and after reset, ic_req=0, ic_addr=RESET_PC, pd_pc=0, pd_ir=NOP and pd_stall=stall_in.
REQ-023 Reset asserted in WAIT SHALL abandon the outstanding request. An ic_ack arriving after reset SHALL be ignored unless the state is WAIT, and the FSM SHALL leave IDLE only per REQ-006.

Verification
REQ-024 Reset, then ic_ack=1 with ic_data=32'h0000_0093 on every WAIT cycle, stall_in=0 -> ic_addr sequence 0x8000_0000, 0x8000_0004, ...; pd_ir=0x0000_0093 with pd_pc=0x8000_0000 two edges after reset release; NOP between fetches.
REQ-025 stall_in=1 held while 5 acks are offered -> exactly 4 pushes, then ic_req stays 0 with count=4; releasing stall_in drains 4 entries in order, one per cycle.
REQ-026 flush=1 with redirect_pc=0x1000 in WAIT with ic_ack=0; ack arrives 3 cycles later -> ack data never appears on pd_ir, and the next ic_req carries ic_addr=0x1000.
REQ-027 flush and ic_ack in the same WAIT cycle with 2 entries queued -> count=0, data discarded, pd_ir=NOP in the flush cycle, next ic_addr=redirect_pc.
REQ-028 Push and pop in the same cycle at count=2, with the pointers crossing DEPTH-1 to 0 -> count stays 2 and the entry order is preserved across the wrap.
REQ-029 rst asserted in WAIT, then ic_ack arrives in the cycle after rst is released -> data discarded, fpc=RESET_PC, and a fresh request is issued to 0x8000_0000.
